// File: rtl/jkms_reg_bank_if.sv
// Signal bundle for the JK master-slave register bank: control/data inputs
// plus the slave-rank outputs. No handshake: inputs are sampled every posedge.
interface jkms_reg_bank_if #(
   parameter int WIDTH = 4
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic             ser_in;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qbar;
   logic             wrap;

   modport master (
      output en, mode, j, k, ser_in,
      input  q, qbar, wrap
   );

   modport slave (
      input  en, mode, j, k, ser_in,
      output q, qbar, wrap
   );
endinterface

// File: rtl/jkms_reg_bank.sv
// WIDTH-bit master-slave JK register bank with JK/count-up/count-down/shift
// modes. Master rank captures on posedge, slave rank presents on negedge.
module jkms_reg_bank #(
   parameter int WIDTH = 4
) (
   input  logic          clk,
   input  logic          clear_n,
   jkms_reg_bank_if.slave bus
);

   localparam logic [1:0] MODE_JK   = 2'b00;
   localparam logic [1:0] MODE_UP   = 2'b01;
   localparam logic [1:0] MODE_DOWN = 2'b10;

   logic [WIDTH-1:0] master_d, master_q;
   logic             master_wrap_d, master_wrap_q;
   logic [WIDTH-1:0] slave_d, slave_q;
   logic             slave_wrap_d, slave_wrap_q;

   // Next state is always derived from the visible slave state, never the master.
   always_comb begin
      master_d      = slave_q;
      master_wrap_d = 1'b0;
      if (bus.en) begin
         case (bus.mode)
            MODE_JK: begin
               for (int i = 0; i < WIDTH; i++) begin
                  case ({bus.j[i], bus.k[i]})
                     2'b00:   master_d[i] = slave_q[i];
                     2'b01:   master_d[i] = 1'b0;
                     2'b10:   master_d[i] = 1'b1;
                     default: master_d[i] = ~slave_q[i];
                  endcase
               end
            end
            MODE_UP: begin
               master_d      = slave_q + WIDTH'(1);
               master_wrap_d = &slave_q;
            end
            MODE_DOWN: begin
               master_d      = slave_q - WIDTH'(1);
               master_wrap_d = ~|slave_q;
            end
            default: begin
               // Concatenate then truncate so WIDTH=1 degenerates to ser_in.
               master_d = WIDTH'({slave_q, bus.ser_in});
            end
         endcase
      end
   end

   always_comb begin
      slave_d      = master_q;
      slave_wrap_d = master_wrap_q;
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         master_q      <= '0;
         master_wrap_q <= 1'b0;
      end else begin
         master_q      <= master_d;
         master_wrap_q <= master_wrap_d;
      end
   end

   always_ff @(negedge clk or negedge clear_n) begin
      if (!clear_n) begin
         slave_q      <= '0;
         slave_wrap_q <= 1'b0;
      end else begin
         slave_q      <= slave_d;
         slave_wrap_q <= slave_wrap_d;
      end
   end

   assign bus.q    = slave_q;
   assign bus.qbar = ~slave_q;
   assign bus.wrap = slave_wrap_q;

endmodule

// File: tb/tb_jkms_reg_bank.sv
// Self-checking bench for jkms_reg_bank at WIDTH=4, 1 and 8 driven in lockstep,
// compared against an arithmetic reference model of the register bank.
module tb_jkms_reg_bank;

   logic clk = 1'b0;
   logic clear_n;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   jkms_reg_bank_if #(.WIDTH(4)) if4 ();
   jkms_reg_bank_if #(.WIDTH(1)) if1 ();
   jkms_reg_bank_if #(.WIDTH(8)) if8 ();

   jkms_reg_bank #(.WIDTH(4)) dut4 (.clk(clk), .clear_n(clear_n), .bus(if4));
   jkms_reg_bank #(.WIDTH(1)) dut1 (.clk(clk), .clear_n(clear_n), .bus(if1));
   jkms_reg_bank #(.WIDTH(8)) dut8 (.clk(clk), .clear_n(clear_n), .bus(if8));

   int          wd [3] = '{4, 1, 8};
   logic [31:0] mq [3];
   logic        mw [3];

   function automatic logic [31:0] mask_of(int w);
      return (32'(1) << w) - 32'(1);
   endfunction

   function automatic logic [31:0] dut_q(int d);
      case (d)
         0:       return 32'(if4.q);
         1:       return 32'(if1.q);
         default: return 32'(if8.q);
      endcase
   endfunction

   function automatic logic [31:0] dut_qbar(int d);
      case (d)
         0:       return 32'(if4.qbar);
         1:       return 32'(if1.qbar);
         default: return 32'(if8.qbar);
      endcase
   endfunction

   function automatic logic dut_wrap(int d);
      case (d)
         0:       return if4.wrap;
         1:       return if1.wrap;
         default: return if8.wrap;
      endcase
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_all(string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s/w%0d/q", tag, wd[d]), dut_q(d), mq[d]);
         chk($sformatf("%s/w%0d/qbar", tag, wd[d]), dut_qbar(d), ~mq[d] & mask_of(wd[d]));
         chk($sformatf("%s/w%0d/wrap", tag, wd[d]), 32'(dut_wrap(d)), 32'(mw[d]));
      end
   endtask

   // Hand-computed WIDTH=4 values, independent of the model.
   task automatic chk4(string tag, logic [3:0] exp_q, logic exp_wrap);
      chk({tag, "/const_q"}, 32'(if4.q), 32'(exp_q));
      chk({tag, "/const_wrap"}, 32'(if4.wrap), 32'(exp_wrap));
   endtask

   task automatic drive(logic en, logic [1:0] mode, logic [31:0] j, logic [31:0] k, logic ser);
      if4.en = en; if4.mode = mode; if4.j = j[3:0]; if4.k = k[3:0]; if4.ser_in = ser;
      if1.en = en; if1.mode = mode; if1.j = j[0:0]; if1.k = k[0:0]; if1.ser_in = ser;
      if8.en = en; if8.mode = mode; if8.j = j[7:0]; if8.k = k[7:0]; if8.ser_in = ser;
   endtask

   task automatic model_next(int w, logic en, logic [1:0] mode, logic [31:0] j, logic [31:0] k,
                             logic ser, logic [31:0] q, output logic [31:0] nq, output logic nw);
      longint m = longint'(1) << w;
      nq = q;
      nw = 1'b0;
      if (en) begin
         case (mode)
            2'd0: begin
               for (int i = 0; i < w; i++) begin
                  if (j[i] && k[i])  nq[i] = ~q[i];
                  else if (j[i])     nq[i] = 1'b1;
                  else if (k[i])     nq[i] = 1'b0;
               end
            end
            2'd1: begin
               nq = 32'((longint'(q) + 1) % m);
               nw = (longint'(q) == m - 1);
            end
            2'd2: begin
               nq = 32'((longint'(q) + m - 1) % m);
               nw = (q == 0);
            end
            default: nq = 32'((longint'(q) * 2 + longint'(ser)) % m);
         endcase
      end
   endtask

   // One posedge/negedge pair; optional late j/k change between the edges.
   task automatic tick(string tag, logic en, logic [1:0] mode, logic [31:0] j, logic [31:0] k,
                       logic ser, logic late = 1'b0, logic [31:0] lj = 0, logic [31:0] lk = 0);
      logic [31:0] nq [3];
      logic        nw [3];
      drive(en, mode, j, k, ser);
      for (int d = 0; d < 3; d++) model_next(wd[d], en, mode, j, k, ser, mq[d], nq[d], nw[d]);
      @(posedge clk); #1;
      check_all({tag, "@pos"});
      if (late) drive(en, mode, lj, lk, ser);
      @(negedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         mq[d] = nq[d];
         mw[d] = nw[d];
      end
      check_all(tag);
   endtask

   // Reset pulse between posedge and negedge while holding; master content must be lost.
   task automatic rst_mid(string tag);
      drive(1'b0, 2'd0, 0, 0, 1'b0);
      @(posedge clk); #2;
      clear_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         mq[d] = '0;
         mw[d] = 1'b0;
      end
      check_all({tag, "@rst"});
      clear_n = 1'b1;
      @(negedge clk); #1;
      check_all({tag, "@neg"});
   endtask

   initial begin
      clear_n = 1'b0;
      drive(1'b0, 2'd0, 0, 0, 1'b0);
      for (int d = 0; d < 3; d++) begin
         mq[d] = '0;
         mw[d] = 1'b0;
      end
      #1;
      check_all("reset");
      chk("reset/const_qbar", 32'(if4.qbar), 32'hF);
      #11;
      clear_n = 1'b1;
      check_all("release");

      tick("hold0", 1'b0, 2'd0, 0, 0, 1'b0); chk4("hold0", 4'h0, 1'b0);
      tick("hold1", 1'b0, 2'd1, 0, 0, 1'b0); chk4("hold1", 4'h0, 1'b0);
      tick("hold2", 1'b0, 2'd2, 0, 0, 1'b0); chk4("hold2", 4'h0, 1'b0);

      tick("jkA", 1'b1, 2'd0, 'hA, 'h5, 1'b0); chk4("jkA", 4'hA, 1'b0);
      rst_mid("rstA");                          chk4("rstA", 4'h0, 1'b0);

      tick("jk1", 1'b1, 2'd0, 'hC, 'h3, 1'b0); chk4("jk1", 4'hC, 1'b0);
      tick("jk2", 1'b1, 2'd0, 'hF, 'hF, 1'b0); chk4("jk2", 4'h3, 1'b0);
      tick("jk3", 1'b1, 2'd0, 'hF, 'hF, 1'b0); chk4("jk3", 4'hC, 1'b0);
      tick("jk4", 1'b1, 2'd0, 'h0, 'h0, 1'b0); chk4("jk4", 4'hC, 1'b0);

      tick("ldD", 1'b1, 2'd0, 'hD, 'h2, 1'b0); chk4("ldD", 4'hD, 1'b0);
      tick("up1", 1'b1, 2'd1, 0, 0, 1'b0);     chk4("up1", 4'hE, 1'b0);
      tick("up2", 1'b1, 2'd1, 0, 0, 1'b0);     chk4("up2", 4'hF, 1'b0);
      tick("up3", 1'b1, 2'd1, 0, 0, 1'b0);     chk4("up3", 4'h0, 1'b1);
      tick("up4", 1'b1, 2'd1, 0, 0, 1'b0);     chk4("up4", 4'h1, 1'b0);

      tick("ld1", 1'b1, 2'd0, 'h1, 'hE, 1'b0); chk4("ld1", 4'h1, 1'b0);
      tick("dn1", 1'b1, 2'd2, 0, 0, 1'b0);     chk4("dn1", 4'h0, 1'b0);
      tick("dn2", 1'b1, 2'd2, 0, 0, 1'b0);     chk4("dn2", 4'hF, 1'b1);
      tick("off1", 1'b0, 2'd2, 0, 0, 1'b0);    chk4("off1", 4'hF, 1'b0);
      tick("off2", 1'b0, 2'd2, 0, 0, 1'b0);    chk4("off2", 4'hF, 1'b0);
      tick("dn3", 1'b1, 2'd2, 0, 0, 1'b0);     chk4("dn3", 4'hE, 1'b0);

      tick("ld0", 1'b1, 2'd0, 'h0, 'hFF, 1'b0); chk4("ld0", 4'h0, 1'b0);
      tick("sh1", 1'b1, 2'd3, 0, 0, 1'b1);      chk4("sh1", 4'h1, 1'b0);
      tick("sh2", 1'b1, 2'd3, 0, 0, 1'b0);      chk4("sh2", 4'h2, 1'b0);
      tick("sh3", 1'b1, 2'd3, 0, 0, 1'b1);      chk4("sh3", 4'h5, 1'b0);
      tick("sh4", 1'b1, 2'd3, 0, 0, 1'b1);      chk4("sh4", 4'hB, 1'b0);
      tick("shup", 1'b1, 2'd1, 0, 0, 1'b0);     chk4("shup", 4'hC, 1'b0);

      tick("late1", 1'b1, 2'd0, 'h0, 'h0, 1'b0, 1'b1, 'h3, 'h0); chk4("late1", 4'hC, 1'b0);
      tick("late2", 1'b1, 2'd0, 'h3, 'h0, 1'b0);                 chk4("late2", 4'hF, 1'b0);

      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 24) == 0) begin
            rst_mid($sformatf("rnd%0d_rst", n));
         end else begin
            tick($sformatf("rnd%0d", n), $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom, $urandom, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) == 0, $urandom, $urandom);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
